tag_packet_sender: RTL

- Parametrised successor to the fixed 10-bit tag data source.
- Buffers several tag words in an internal FIFO.
- When the demodulator's `sending` window opens, it serialises one word per window, framed by a preamble, with a programmable bit period and selectable NRZ or Manchester line coding.
- Sits between the tag-data producer and the backscatter modulator input (`output_data`).

---
 rtl/tag_packet_sender.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/tag_packet_sender.sv
// tag_packet_sender: FIFO-buffered tag word serialiser with preamble,
// programmable bit period and NRZ / Manchester line coding.
module tag_packet_sender #(
    parameter int               DATA_W     = 10,
    parameter int               DEPTH      = 4,
    parameter int               BIT_CYCLES = 8,
    parameter int               PRE_W      = 4,
    parameter logic [PRE_W-1:0] PRE_VAL    = 4'b1010
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic                       sending,
    input  logic                       mode,
    output logic                       output_data,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       underrun,
    output logic                       abort
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PH_W  = $clog2(BIT_CYCLES);
    localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int EXT_W = 1 << IDX_W;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BIT_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(BIT_CYCLES / 2);
    localparam logic [IDX_W-1:0] PRE_TOP  = IDX_W'(PRE_W - 1);
    localparam logic [IDX_W-1:0] DATA_TOP = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA
    } state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              sending_q;
    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic              mode_q;
    logic [IDX_W-1:0]  idx_q;
    logic [PH_W-1:0]   phase_q;
    logic              out_q;
    logic              underrun_q;
    logic              abort_q;

    logic              start;
    logic              push;
    logic              pop;
    logic [EXT_W-1:0]  pre_ext;
    logic [EXT_W-1:0]  dat_ext;
    logic [PH_W-1:0]   phase_inc;
    logic [IDX_W-1:0]  idx_dec;
    logic              cur_bit;
    logic              nxt_bit;

    // Line coder: Manchester inverts the bit in the second half-period.
    function automatic logic enc(input logic b,
                                 input logic [PH_W-1:0] ph,
                                 input logic m);
        return (m && (ph >= PH_HALF)) ? ~b : b;
    endfunction

    assign wr_ready  = (count_q < CNT_FULL);
    assign push      = wr_valid & wr_ready;
    assign start     = sending & ~sending_q;
    assign pop       = start & (state_q == IDLE) & (count_q != '0);

    // Zero-extended views so the bit index always spans the vector.
    assign pre_ext   = EXT_W'(PRE_VAL);
    assign dat_ext   = EXT_W'(shift_q);
    assign phase_inc = phase_q + 1'b1;
    assign idx_dec   = idx_q - 1'b1;
    assign cur_bit   = (state_q == PRE) ? pre_ext[idx_q] : dat_ext[idx_q];
    assign nxt_bit   = (state_q == PRE) ? pre_ext[idx_dec] : dat_ext[idx_dec];

    assign output_data = out_q;
    assign busy        = (state_q != IDLE);
    assign fifo_count  = count_q;
    assign underrun    = underrun_q;
    assign abort       = abort_q;

    // FIFO storage: written on accepted pushes only.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Packet FSM: output register always holds the coded value for the
    // phase described by state_q/idx_q/phase_q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sending_q  <= 1'b0;
            state_q    <= IDLE;
            shift_q    <= '0;
            mode_q     <= 1'b0;
            idx_q      <= '0;
            phase_q    <= '0;
            out_q      <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            sending_q  <= sending;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    out_q <= 1'b0;
                    if (start) begin
                        if (count_q != '0) begin
                            shift_q <= mem_q[rd_ptr_q];
                            mode_q  <= mode;
                            idx_q   <= PRE_TOP;
                            phase_q <= '0;
                            state_q <= PRE;
                            out_q   <= enc(PRE_VAL[PRE_W-1], '0, mode);
                        end else begin
                            underrun_q <= 1'b1;
                        end
                    end
                end
                PRE, DATA: begin
                    if (!sending) begin
                        state_q <= IDLE;
                        out_q   <= 1'b0;
                        abort_q <= 1'b1;
                    end else if (phase_q != PH_LAST) begin
                        phase_q <= phase_inc;
                        out_q   <= enc(cur_bit, phase_inc, mode_q);
                    end else if (idx_q != '0) begin
                        idx_q   <= idx_dec;
                        phase_q <= '0;
                        out_q   <= enc(nxt_bit, '0, mode_q);
                    end else if (state_q == PRE) begin
                        state_q <= DATA;
                        idx_q   <= DATA_TOP;
                        phase_q <= '0;
                        out_q   <= enc(shift_q[DATA_W-1], '0, mode_q);
                    end else begin
                        state_q <= IDLE;
                        out_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    out_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
